// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader into instruction memory.
// Optional checksum byte enabled by `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        err
);

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state;
  state_t      state_nx;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic        accept;
  logic        last_byte;
  logic [15:0] n_rx;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept    = byte_valid & byte_ready;
  assign n_rx      = {byte_data, count[7:0]};
  assign last_byte = (byte_cnt == 2'd3) &&
                     ((word_idx + 16'd1) == count);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CNT_LO;
    else       state <= state_nx;
  end

  // next-state decode and state-derived status outputs
  always_comb begin
    state_nx   = state;
    byte_ready = 1'b1;
    load_done  = 1'b0;
    err        = 1'b0;
    cpu_reset  = 1'b1;
    unique case (state)
      CNT_LO: if (accept) state_nx = CNT_HI;
      CNT_HI: begin
        if (accept) begin
          if ({1'b0, n_rx} > MAX_N) state_nx = ERROR;
          else if (n_rx == 16'd0)   state_nx = DONE;
          else                      state_nx = DATA;
        end
      end
      DATA: begin
        if (accept && last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_nx = CSUM;
`else
          state_nx = DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept)
          state_nx = (byte_data == csum) ? DONE : ERROR;
      end
`endif
      DONE: begin
        byte_ready = 1'b0;
        load_done  = 1'b1;
        cpu_reset  = 1'b0;
      end
      ERROR: begin
        byte_ready = 1'b0;
        err        = 1'b1;
      end
      default: state_nx = CNT_LO;
    endcase
  end

  // count capture, word assembly and memory write strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      partial    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        unique case (state)
          CNT_LO: count[7:0] <= byte_data;
          CNT_HI: begin
            count[15:8] <= byte_data;
            word_idx    <= '0;
            byte_cnt    <= '0;
          end
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_data;
`endif
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= BASE_ADDR +
                            {14'd0, word_idx, 2'b00};
              imem_wdata <= {byte_data, partial};
              partial    <= '0;
              word_idx   <= word_idx + 16'd1;
            end else begin
              partial <= {byte_data, partial[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader.
// Covers reset, directed streams, limits and random loads.
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done),
    .err(err)
  );

  always #5 clk = ~clk;

  // record every write strobe seen mid-cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  task automatic drive(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    got_addr.delete();
    got_data.delete();
  endtask

  // reference: the stream alone decides writes and outcome
  task automatic check_load(input string name, input bq_t s,
                            input int gapmax);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [7:0]  x;
    logic [15:0] n;
    bit          exp_err;
    int          nw;
    int          gap;
    x = 8'h00;
    exp_err = 1'b0;
    n = {s[1], s[0]};
    nw = int'(n);
    if (nw > MAXW) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < nw; i++) begin
        ea.push_back(BASE + 32'(4 * i));
        ed.push_back({s[2+4*i+3], s[2+4*i+2],
                      s[2+4*i+1], s[2+4*i]});
        for (int k = 0; k < 4; k++) x = x ^ s[2+4*i+k];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (nw != 0) exp_err = (s[2+4*nw] != x);
`endif
    end
    got_addr.delete();
    got_data.delete();
    for (int i = 0; i < s.size(); i++) begin
      gap = (i == s.size() - 1) ? 0 : $urandom_range(gapmax, 0);
      drive(s[i], gap);
    end
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("FAIL %s err: got %b want %b", name, err, exp_err);
    end
    vectors++;
    if (load_done !== !exp_err) begin
      miscompares++;
      $display("FAIL %s load_done: got %b want %b",
               name, load_done, !exp_err);
    end
    vectors++;
    if (cpu_reset !== exp_err) begin
      miscompares++;
      $display("FAIL %s cpu_reset: got %b want %b",
               name, cpu_reset, exp_err);
    end
    vectors++;
    if (byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s byte_ready: got %b want 0", name, byte_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (got_addr.size() != ea.size()) begin
      miscompares++;
      $display("FAIL %s write count: got %0d want %0d",
               name, got_addr.size(), ea.size());
    end else begin
      for (int i = 0; i < ea.size(); i++) begin
        vectors++;
        if (got_addr[i] !== ea[i] || got_data[i] !== ed[i]) begin
          miscompares++;
          $display("FAIL %s write %0d: got %h/%h want %h/%h", name,
                   i, got_addr[i], got_data[i], ea[i], ed[i]);
        end
      end
    end
    vectors++;
    if (imem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL %s imem_we idle: got %b want 0", name, imem_we);
    end
    if (ea.size() > 0) begin
      vectors++;
      if (imem_addr !== ea[$] || imem_wdata !== ed[$]) begin
        miscompares++;
        $display("FAIL %s hold: got %h/%h want %h/%h", name,
                 imem_addr, imem_wdata, ea[$], ed[$]);
      end
    end
  endtask

  function automatic bq_t basic_stream();
    bq_t s;
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
          8'h93, 8'h00, 8'hA0, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
    s.push_back(8'h70);
`endif
    return s;
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    vectors++;
    if (byte_ready !== 1'b1 || imem_we !== 1'b0 ||
        imem_addr !== BASE || imem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset datapath: got rdy=%b we=%b a=%h d=%h want 1 0 %h 0",
               byte_ready, imem_we, imem_addr, imem_wdata, BASE);
    end
    vectors++;
    if (cpu_reset !== 1'b1 || load_done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset status: got cr=%b ld=%b err=%b want 1 0 0",
               cpu_reset, load_done, err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    check_load("basic", basic_stream(), 0);
  endtask

  task automatic test_idle_gaps();
    do_reset();
    check_load("gaps", basic_stream(), 3);
  endtask

  task automatic test_zero_count();
    bq_t s;
    s = '{8'h00, 8'h00};
    do_reset();
    check_load("zero", s, 0);
  endtask

  task automatic test_overflow();
    bq_t s;
    s = '{8'h41, 8'h00};
    for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
    do_reset();
    check_load("over65", s, 1);
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    check_load("over256", s, 0);
  endtask

  task automatic test_midload_reset();
    bq_t s;
    do_reset();
    s = '{8'h02, 8'h00, 8'h13, 8'h00};
    foreach (s[i]) drive(s[i], 0);
    reset = 1'b1;
    #1;
    vectors++;
    if (imem_we !== 1'b0 || byte_ready !== 1'b1 ||
        cpu_reset !== 1'b1 || imem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset: got we=%b rdy=%b cr=%b d=%h want 0 1 1 0",
               imem_we, byte_ready, cpu_reset, imem_wdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    check_load("after_reset", basic_stream(), 0);
    do_reset();
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    foreach (s[i]) drive(s[i], 0);
    vectors++;
    if (imem_we !== 1'b1 || imem_wdata !== 32'hDDCCBBAA) begin
      miscompares++;
      $display("FAIL pulse: got we=%b d=%h want 1 ddccbbaa",
               imem_we, imem_wdata);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (imem_we !== 1'b0 || imem_addr !== BASE) begin
      miscompares++;
      $display("FAIL pulse_kill: got we=%b a=%h want 0 %h",
               imem_we, imem_addr, BASE);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    bq_t s;
    int  n;
    logic [7:0] x;
    for (int t = 0; t < 8; t++) begin
      if (t == 0)      n = 1;
      else if (t == 1) n = MAXW;
      else             n = $urandom_range(MAXW, 1);
      s.delete();
      x = 8'h00;
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      for (int i = 0; i < 4 * n; i++) begin
        s.push_back(8'($urandom));
        x = x ^ s[$];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if ($urandom_range(3, 0) == 0) x = x ^ 8'h5A;
      s.push_back(x);
`endif
      do_reset();
      check_load($sformatf("rand%0d", t), s, (t % 2) * 3);
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bq_t s;
    s = basic_stream();
    s[s.size()-1] = 8'h71;
    do_reset();
    check_load("csum_bad", s, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_idle_gaps();
    test_zero_count();
    test_overflow();
    test_midload_reset();
    test_random();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 64: largest accepted word count; must be 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 byte_valid  input  1  a loader stream byte is present on byte_data.
REQ-006 byte_data  input  8  loader stream byte.
REQ-007 byte_ready  output  1  block can accept a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  32  word-aligned byte address for the write.
REQ-010 imem_wdata  output  32  instruction word for the write.
REQ-011 cpu_reset  output  1  holds the processor in reset while high.
REQ-012 load_done  output  1  program loaded and accepted.
REQ-013 err  output  1  load rejected; sticky until reset.

Function
REQ-014 A byte SHALL be accepted only on a rising edge where byte_valid and byte_ready are both 1; a byte offered while byte_ready is 0 SHALL be ignored, not buffered.
REQ-015 Stream format SHALL be: count low byte, count high byte (16-bit N, little-endian), then 4*N payload bytes, then one checksum byte only when CHECKSUM_EN is defined.
REQ-016 States SHALL be CNT_LO, CNT_HI, DATA, CSUM (CHECKSUM_EN only), DONE and ERROR.
REQ-017 byte_ready SHALL be 1 in CNT_LO, CNT_HI, DATA and CSUM, and 0 in DONE and ERROR.
REQ-018 CNT_LO -> CNT_HI on an accepted byte.
REQ-019 On the accepted CNT_HI byte: N > MAX_WORDS -> ERROR; N = 0 -> DONE (checksum byte not expected); otherwise -> DATA.
REQ-020 Payload SHALL be assembled little-endian: the k-th byte of a word (k = 0..3) lands in bits [8k+7:8k].
REQ-021 On the edge accepting byte k = 3 of word i, the block SHALL register imem_we=1, imem_addr=BASE_ADDR+4*i and imem_wdata=the assembled word; imem_we SHALL be 1 for exactly the next cycle and 0 otherwise.
REQ-022 imem_addr and imem_wdata SHALL hold their last values while imem_we is 0.
REQ-023 Byte acceptance SHALL NOT stall around writes: back-to-back bytes on consecutive cycles SHALL be accepted without loss.
REQ-024 After the last byte of word N-1 the block SHALL go to CSUM if CHECKSUM_EN is defined, and to DONE otherwise.
REQ-025 In DONE: load_done=1, cpu_reset=0, err=0, starting on the cycle after the transition edge.
REQ-026 In ERROR: err=1, cpu_reset=1, load_done=0, and no further imem writes.
REQ-027 DONE and ERROR SHALL be left only through reset.
REQ-028 Word index and byte counters SHALL be 16 and 2 bits wide; the byte counter wraps 3->0 at each word boundary.

Reset
REQ-029 While reset=1, independent of clk, the outputs SHALL be: state=CNT_LO, byte_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_reset=1, load_done=0, err=0, and all counters, the partial word and the checksum accumulator SHALL be 0.
REQ-030 Reset asserted mid-load SHALL discard the partial word and force imem_we=0 immediately; after release, loading SHALL restart from CNT_LO.

Configuration
REQ-031 Macro PROG_LOADER_CHECKSUM_EN: when defined, the block SHALL keep a running 8-bit XOR of all payload bytes (not the count bytes). The CSUM byte SHALL be compared against it: equal -> DONE, else -> ERROR. The words are already written to memory, but cpu_reset SHALL stay 1 on mismatch.
REQ-032 When PROG_LOADER_CHECKSUM_EN is undefined, the CSUM state, the accumulator and the checksum byte SHALL be absent.

Verification
REQ-033 Stream 02 00 13 00 50 00 93 00 A0 00 on consecutive cycles, no checksum -> writes (0x00000000, 0x00500013) then (0x00000004, 0x00A00093); load_done=1 and cpu_reset=0 on the cycle after the last byte.
REQ-034 Same stream with 1-3 idle cycles between bytes -> identical writes and final state.
REQ-035 Count 00 00 -> DONE after the second byte, zero imem_we pulses.
REQ-036 Count 41 00 (65 > MAX_WORDS) -> err=1, byte_ready=0, cpu_reset=1, no writes; further bytes are ignored.
REQ-037 reset pulsed after two payload bytes of word 0 -> imem_we=0 during reset; then the full stream from REQ-033 produces exactly the two writes of REQ-033.
REQ-038 CHECKSUM_EN: stream of REQ-033 plus byte 70 -> load_done=1; plus byte 71 -> err=1 and cpu_reset stays 1.
